// File: rtl/memoria_pkg.sv
// memoria_pkg: shared encodings for the clocked MIPS data memory.
// Size codes for the access width, FSM state encoding and byte-lane constants.
package memoria_pkg;

    // Access width encodings as they arrive on Size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Byte lanes per word and bits per lane.
    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    // Access FSM: IDLE (free), WAIT (modelling slow memory), DONE (completion cycle).
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/memoria_lane_ctrl.sv
// memoria_lane_ctrl: combinational big-endian lane steering for byte/half/word
// accesses. Produces byte enables, the replicated store word, the extracted and
// extended load word and a misalignment flag.
// The misalignment check exists only when MEMORIA_MISALIGN_ERR_EN is defined;
// otherwise offsets are forced aligned and the flag is constant 0.
module memoria_lane_ctrl
    import memoria_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        unsgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [LANE_W-1:0] byte_v;
    logic [15:0]       half_v;

    // Lane selection: offset 0 is the most significant byte; reserved size acts as word.
    always_comb begin
        be     = 4'b1111;
        wword  = wdata;
        byte_v = rword[7:0];
        half_v = rword[15:0];
        rdata  = rword;
        unique case (size)
            SZ_BYTE: begin
                be    = 4'b1000 >> offset;
                wword = {LANES{wdata[7:0]}};
                unique case (offset)
                    2'd0:    byte_v = rword[31:24];
                    2'd1:    byte_v = rword[23:16];
                    2'd2:    byte_v = rword[15:8];
                    default: byte_v = rword[7:0];
                endcase
                rdata = {{24{~unsgn & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                be     = offset[1] ? 4'b0011 : 4'b1100;
                wword  = {2{wdata[15:0]}};
                half_v = offset[1] ? rword[15:0] : rword[31:16];
                rdata  = {{16{~unsgn & half_v[15]}}, half_v};
            end
            default: begin
                be    = 4'b1111;
                wword = wdata;
                rdata = rword;
            end
        endcase
    end

    // Misalignment detection: half on an odd byte, word off a word boundary, reserved size.
    always_comb begin
        misalign = 1'b0;
`ifdef MEMORIA_MISALIGN_ERR_EN
        unique case (size)
            SZ_HALF: misalign = offset[0];
            SZ_WORD: misalign = |offset;
            SZ_RSVD: misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
`endif
    end

endmodule

// File: rtl/memoria_datos_sync.sv
// memoria_datos_sync: clocked MIPS data memory with byte/half/word access,
// big-endian lanes, sign/zero-extended loads and a programmable wait-state FSM.
// Optional feature macro: MEMORIA_MISALIGN_ERR_EN (flag and suppress misaligned
// accesses with Err). Undefined: offsets are forced aligned and Err stays 0.
//
// Handshake: a request is taken on any rising edge where Req=1 and Busy=0
// (state IDLE or DONE); requests seen while Busy=1 are dropped, so the
// requester keeps Req high until it sees Busy=0 at an edge. Completion is the
// single-cycle Ready pulse; DataR and Err are valid while Ready=1.
module memoria_datos_sync
    import memoria_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        Wen,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Adress,
    input  logic [31:0] DataW,
    output logic [31:0] DataR,
    output logic        Ready,
    output logic        Busy,
    output logic        Err,
    output logic [1:0]  dbg_state
);

    localparam bit         NO_WAIT    = (WAIT_STATES == 0);
    localparam int         CNT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

    state_t             state_q, state_d;
    logic [3:0]         cnt_q;
    logic               accept, commit;

    logic               l_wen, l_uns;
    logic [1:0]         l_size;
    logic [ADDR_W-1:0]  l_addr;
    logic [31:0]        l_wdata;

    logic               cur_wen, cur_uns;
    logic [1:0]         cur_size;
    logic [ADDR_W-1:0]  cur_addr;
    logic [31:0]        cur_wdata;
    logic [ADDR_W-3:0]  word_idx;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        rd_word;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wword, lane_rdata;
    logic               lane_misalign;

    // Address bits above the decoded range are deliberately ignored (address wraps).
    logic               unused_addr_hi;
    assign unused_addr_hi = ^Adress[31:ADDR_W];

    assign accept = Req && (state_q == ST_IDLE || state_q == ST_DONE);
    assign commit = (NO_WAIT && accept) || (state_q == ST_WAIT && cnt_q == 4'd0);

    // Without wait states the access commits on the accept edge, straight from the inputs.
    assign cur_wen   = NO_WAIT ? Wen                : l_wen;
    assign cur_uns   = NO_WAIT ? Unsigned           : l_uns;
    assign cur_size  = NO_WAIT ? Size               : l_size;
    assign cur_addr  = NO_WAIT ? Adress[ADDR_W-1:0] : l_addr;
    assign cur_wdata = NO_WAIT ? DataW              : l_wdata;
    assign word_idx  = cur_addr[ADDR_W-1:2];
    assign rd_word   = mem[word_idx];

    memoria_lane_ctrl u_lanes (
        .size     (cur_size),
        .offset   (cur_addr[1:0]),
        .unsgn    (cur_uns),
        .wdata    (cur_wdata),
        .rword    (rd_word),
        .be       (lane_be),
        .wword    (lane_wword),
        .rdata    (lane_rdata),
        .misalign (lane_misalign)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: accept from IDLE/DONE, count down in WAIT, fall back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Req) state_d = NO_WAIT ? ST_DONE : ST_WAIT;
                else     state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: Ready only in DONE, Busy only in WAIT.
    always_comb begin
        Ready     = (state_q == ST_DONE);
        Busy      = (state_q == ST_WAIT);
        dbg_state = state_q;
    end

    // Wait counter: loaded on accept, decremented while waiting.
    always_ff @(posedge Clk) begin
        if (Rst)                                 cnt_q <= 4'd0;
        else if (accept && !NO_WAIT)             cnt_q <= CNT_INIT;
        else if (state_q == ST_WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
    end

    // Request latch: captures the access fields on the accept edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            l_wen   <= 1'b0;
            l_uns   <= 1'b0;
            l_size  <= SZ_BYTE;
            l_addr  <= '0;
            l_wdata <= '0;
        end else if (accept) begin
            l_wen   <= Wen;
            l_uns   <= Unsigned;
            l_size  <= Size;
            l_addr  <= Adress[ADDR_W-1:0];
            l_wdata <= DataW;
        end
    end

    // Array write: only the enabled lanes; reset on the commit edge drops the write.
    always_ff @(posedge Clk) begin
        if (!Rst && commit && cur_wen && !lane_misalign) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_be[i]) mem[word_idx][i*LANE_W +: LANE_W] <= lane_wword[i*LANE_W +: LANE_W];
            end
        end
    end

    // Load result and error flag, registered on the commit edge from pre-write array contents.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            DataR <= 32'd0;
            Err   <= 1'b0;
        end else begin
            Err <= commit && lane_misalign;
            if (commit && !cur_wen && !lane_misalign) DataR <= lane_rdata;
        end
    end

endmodule

// File: tb/tb_memoria_datos_sync.sv
// tb_memoria_datos_sync: directed bench for memoria_datos_sync. Two instances run
// side by side (no wait states and three wait states) against a byte-array model.
module tb_memoria_datos_sync;
  import memoria_pkg::*;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i   [2];
  logic        req_i   [2];
  logic        wen_i   [2];
  logic        uns_i   [2];
  logic [1:0]  size_i  [2];
  logic [31:0] addr_i  [2];
  logic [31:0] dataw_i [2];
  logic [31:0] datar_o [2];
  logic        ready_o [2];
  logic        busy_o  [2];
  logic        err_o   [2];
  logic [1:0]  dbg_o   [2];

  memoria_datos_sync #(.DEPTH(256), .ADDR_W(10), .WAIT_STATES(WS0)) u_ws0 (
    .Clk(clk), .Rst(rst_i[0]), .Req(req_i[0]), .Wen(wen_i[0]), .Size(size_i[0]),
    .Unsigned(uns_i[0]), .Adress(addr_i[0]), .DataW(dataw_i[0]), .DataR(datar_o[0]),
    .Ready(ready_o[0]), .Busy(busy_o[0]), .Err(err_o[0]), .dbg_state(dbg_o[0])
  );

  memoria_datos_sync #(.DEPTH(256), .ADDR_W(10), .WAIT_STATES(WS1)) u_ws3 (
    .Clk(clk), .Rst(rst_i[1]), .Req(req_i[1]), .Wen(wen_i[1]), .Size(size_i[1]),
    .Unsigned(uns_i[1]), .Adress(addr_i[1]), .DataW(dataw_i[1]), .DataR(datar_o[1]),
    .Ready(ready_o[1]), .Busy(busy_o[1]), .Err(err_o[1]), .dbg_state(dbg_o[1])
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(int k, string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (dut%0d) actual=%h required=%h", name, k, act, exp);
    end
  endtask

  task automatic fail_now(int k, string name);
    total++;
    bad++;
    $display("FAIL %s (dut%0d) actual=timeout required=event", name, k);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mb [2][1024];
  int          pend [2];
  bit          acc [2];
  logic        exp_ready [2];
  logic        exp_busy  [2];
  logic        exp_err   [2];
  logic [31:0] exp_datar [2];
  logic        p_w [2], p_u [2];
  logic [1:0]  p_sz [2];
  logic [31:0] p_a [2], p_d [2];
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  function automatic int ws_of(int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  // One access applied to a byte-addressed big-endian image (lowest address = MSB).
  task automatic do_access(int k, logic w, logic [1:0] sz, logic u, logic [31:0] a, logic [31:0] d);
    int base;
    int n;
    logic mis;
    logic [31:0] v;
    base = int'(a[9:0]);
    n = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    mis = 1'b0;
`ifdef MEMORIA_MISALIGN_ERR_EN
    mis = (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a[1:0] != 2'd0) || (sz == SZ_RSVD);
`else
    if (n == 2) base = base - (base % 2);
    if (n == 4) base = base - (base % 4);
`endif
    if (!mis) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[k][base + i] = 8'(d >> (8 * (n - 1 - i)));
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mb[k][base + i]);
        if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        exp_datar[k] = v;
      end
    end
    exp_err[k] = mis;
    if (k == 0) exp_q0.push_back({mis, exp_datar[k]});
    else        exp_q1.push_back({mis, exp_datar[k]});
  endtask

  // Model step: what the outputs must look like after each rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      acc[k] = 1'b0;
      if (rst_i[k]) begin
        pend[k] = 0;
        exp_ready[k] = 1'b0;
        exp_busy[k]  = 1'b0;
        exp_err[k]   = 1'b0;
        exp_datar[k] = 32'd0;
      end else if (pend[k] > 0) begin
        pend[k] = pend[k] - 1;
        exp_ready[k] = 1'b0;
        exp_err[k]   = 1'b0;
        if (pend[k] == 0) begin
          do_access(k, p_w[k], p_sz[k], p_u[k], p_a[k], p_d[k]);
          exp_ready[k] = 1'b1;
        end
        exp_busy[k] = (pend[k] > 0);
      end else begin
        exp_ready[k] = 1'b0;
        exp_busy[k]  = 1'b0;
        exp_err[k]   = 1'b0;
        if (req_i[k]) begin
          acc[k] = 1'b1;
          p_w[k] = wen_i[k]; p_sz[k] = size_i[k]; p_u[k] = uns_i[k];
          p_a[k] = addr_i[k]; p_d[k] = dataw_i[k];
          if (ws_of(k) == 0) begin
            do_access(k, p_w[k], p_sz[k], p_u[k], p_a[k], p_d[k]);
            exp_ready[k] = 1'b1;
          end else begin
            pend[k] = ws_of(k);
            exp_busy[k] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        check(k, "cyc_ready", 32'(ready_o[k]), 32'(exp_ready[k]));
        check(k, "cyc_busy",  32'(busy_o[k]),  32'(exp_busy[k]));
        check(k, "cyc_datar", datar_o[k], exp_datar[k]);
        if (ready_o[k] === 1'b1) begin
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            fail_now(k, "ready_without_access");
          end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check(k, "cpl_err",   32'(err_o[k]), 32'(e[32]));
            check(k, "cpl_datar", datar_o[k], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a negedge; holds Req until the model reports acceptance.
  task automatic issue(int k, logic w, logic [1:0] sz, logic u, logic [31:0] a, logic [31:0] d);
    req_i[k] = 1'b1; wen_i[k] = w; size_i[k] = sz; uns_i[k] = u;
    addr_i[k] = a; dataw_i[k] = d;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (acc[k]) begin
        req_i[k] = 1'b0;
        return;
      end
    end
    req_i[k] = 1'b0;
    fail_now(k, "accept");
  endtask

  task automatic wait_ready(int k, string name, logic [31:0] lit_data, logic lit_err);
    for (int n = 0; n < 40; n++) begin
      if (ready_o[k] === 1'b1) begin
        check(k, {name, "_data"},  datar_o[k], lit_data);
        check(k, {name, "_model"}, exp_datar[k], lit_data);
        check(k, {name, "_err"},   32'(err_o[k]), 32'(lit_err));
        return;
      end
      @(negedge clk);
    end
    fail_now(k, {name, "_ready"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_i[k] = 1'b1; req_i[k] = 1'b0; wen_i[k] = 1'b0; uns_i[k] = 1'b0;
      size_i[k] = SZ_WORD; addr_i[k] = 32'd0; dataw_i[k] = 32'd0;
      pend[k] = 0; acc[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(k, "rst_ready", 32'(ready_o[k]), 32'd0);
      check(k, "rst_busy",  32'(busy_o[k]),  32'd0);
      check(k, "rst_err",   32'(err_o[k]),   32'd0);
      check(k, "rst_datar", datar_o[k],      32'd0);
      rst_i[k] = 1'b0;
    end
    chk_on = 1'b1;

    // No wait states: store then load on consecutive cycles.
    issue(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344);
    check(0, "t1_sw_ready", 32'(ready_o[0]), 32'd1);
    issue(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    wait_ready(0, "t1_lw", 32'h1122_3344, 1'b0);

    // Byte store and sign/zero-extended byte loads.
    issue(0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h1234_56AB);
    issue(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0);
    wait_ready(0, "t2_lb", 32'hFFFF_FFAB, 1'b0);
    issue(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0);
    wait_ready(0, "t2_lbu", 32'h0000_00AB, 1'b0);
    issue(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    wait_ready(0, "t2_lw", 32'h1122_33AB, 1'b0);
    issue(0, 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0);
    wait_ready(0, "t2_lb0", 32'h0000_0011, 1'b0);

    // Half store at offset 2 and half loads at both offsets.
    issue(0, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'hFFFF_8001);
    issue(0, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0);
    wait_ready(0, "t2_lhu", 32'h0000_1122, 1'b0);
    issue(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    wait_ready(0, "t2_lw2", 32'h1122_8001, 1'b0);
    issue(0, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0);
    wait_ready(0, "t2_lh", 32'hFFFF_8001, 1'b0);

    // Misaligned word load.
    issue(0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h5566_7788);
    issue(0, 1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0);
`ifdef MEMORIA_MISALIGN_ERR_EN
    wait_ready(0, "t5_lw_mis", 32'hFFFF_8001, 1'b1);
`else
    wait_ready(0, "t5_lw_mis", 32'h5566_7788, 1'b0);
`endif
    issue(0, 1'b0, SZ_RSVD, 1'b0, 32'h20, 32'h0);
    wait_ready(0, "t5_rsvd", exp_datar[0], exp_err[0]);

    // Address wrap above the decoded range.
    issue(0, 1'b1, SZ_WORD, 1'b0, 32'h404, 32'hCAFE_F00D);
    issue(0, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    wait_ready(0, "t6_wrap", 32'hCAFE_F00D, 1'b0);
    repeat (2) @(negedge clk);
    check(0, "t6_idle_ready", 32'(ready_o[0]), 32'd0);

    // Three wait states: latency, Busy window, ignored request.
    issue(1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344);
    wait_ready(1, "t3_sw", 32'h0, 1'b0);
    @(negedge clk);
    issue(1, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0);
    check(1, "t3_busy_t1", 32'(busy_o[1]), 32'd1);
    @(negedge clk);
    check(1, "t3_busy_t2", 32'(busy_o[1]), 32'd1);
    req_i[1] = 1'b1; wen_i[1] = 1'b1; size_i[1] = SZ_WORD; addr_i[1] = 32'h30; dataw_i[1] = 32'h7777_7777;
    @(negedge clk);
    check(1, "t3_busy_t3", 32'(busy_o[1]), 32'd1);
    req_i[1] = 1'b0;
    @(negedge clk);
    check(1, "t3_ready_t4", 32'(ready_o[1]), 32'd1);
    check(1, "t3_lh_data",  datar_o[1], 32'h0000_1122);
    @(negedge clk);
    check(1, "t3_ignored_req", 32'(ready_o[1]), 32'd0);

    // Reset in WAIT drops an in-flight store.
    issue(1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0102_0304);
    wait_ready(1, "t4_old_sw", 32'h0000_1122, 1'b0);
    @(negedge clk);
    issue(1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEAD_BEEF);
    rst_i[1] = 1'b1;
    @(negedge clk);
    rst_i[1] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check(1, "t4_no_ready", 32'(ready_o[1]), 32'd0);
      @(negedge clk);
    end
    issue(1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
    wait_ready(1, "t4_lw_old", 32'h0102_0304, 1'b0);
    repeat (3) @(negedge clk);

    check(0, "q_empty", 32'(exp_q0.size()), 32'd0);
    check(1, "q_empty", 32'(exp_q1.size()), 32'd0);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
